temporal_window_sequencer: RTL and testbench
============================================

TEMPORAL_WINDOW_SEQUENCER -- requirements
Module: temporal_window_sequencer

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8: number of temporal input lines.
REQ-002 SHALL have parameter WINDOW, default 8: capture-window length in cycles; also the "no spike" time code.
REQ-003 SHALL have parameter GAP, default 2: idle cycles after drain for downstream decoder clearance; 0 legal.
REQ-004 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  request a new window; honoured only in IDLE.
REQ-007 SHALL have port incoming_lines  in  NUM_LINES  one pulse line per input; high = spike this cycle.
REQ-008 SHALL have port window_start  out  1  one-cycle pulse on the first CAPTURE cycle, re-arms decoders.
REQ-009 SHALL have port window_open  out  1  high during every CAPTURE cycle.
REQ-010 SHALL have port busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port out_valid  out  1  result word valid.
REQ-012 SHALL have port out_ready  in  1  downstream accepts the word when out_valid and out_ready are both high.
REQ-013 SHALL have port out_index  out  $clog2(NUM_LINES)  line number of the current word.
REQ-014 SHALL have port out_time  out  $clog2(WINDOW+1)  arrival time of that line; WINDOW = silent.
REQ-015 SHALL have port out_last  out  1  high with the word for index NUM_LINES-1.

Function
REQ-016 SHALL implement states IDLE, CAPTURE, DRAIN, GAP.
REQ-017 IDLE -> CAPTURE on the cycle after start=1 is sampled; start in any other state SHALL be ignored.
REQ-018 Tick counter SHALL be 0 on the first CAPTURE cycle and increment each cycle; CAPTURE -> DRAIN after the cycle with tick = WINDOW-1, so CAPTURE lasts exactly WINDOW cycles.
REQ-019 In CAPTURE, a line high while not yet captured SHALL record time = current tick and mark captured; later pulses on that line SHALL be ignored.
REQ-020 Several lines high in the same cycle SHALL all be captured with the same tick.
REQ-021 Pulses outside CAPTURE, including the cycle start is sampled, SHALL be ignored.
REQ-022 Lines never captured SHALL report out_time = WINDOW.
REQ-023 DRAIN SHALL present indices 0..NUM_LINES-1 in ascending order, one word at a time, out_valid high throughout.
REQ-024 While out_valid=1 and out_ready=0, out_index, out_time and out_last SHALL hold stable.
REQ-025 The index SHALL advance on each handshake; the handshake with out_last=1 SHALL move DRAIN -> GAP, or -> IDLE if GAP = 0.
REQ-026 GAP SHALL last exactly GAP cycles, then go to IDLE; all capture flags SHALL be cleared on GAP/IDLE entry.
REQ-027 Minimum start-to-start period with out_ready tied high SHALL be 1 + WINDOW + NUM_LINES + GAP cycles.
REQ-028 out_valid SHALL be 0 in every state except DRAIN.

Reset
REQ-029 On reset=0, state SHALL go to IDLE immediately; tick, index, captured flags and times SHALL clear to 0.
REQ-030 During reset, window_start, window_open, busy, out_valid and out_last SHALL be 0; out_index 0 and out_time 0.
REQ-031 Reset asserted mid-CAPTURE or mid-DRAIN SHALL discard the window, emit no further words and require a fresh start.

Structure
REQ-032 Package temporal_pkg SHALL hold the state enum and width helpers for index and time widths.
REQ-033 Per-line capture SHALL be a sub-module arrival_capture (captured flag plus time register), instantiated NUM_LINES times.

Verification
REQ-034 Pulses on line 0 at tick 0, line 3 at tick 5 and line 7 at tick 7, out_ready=1 -> times 0,8,8,5,8,8,8,7; out_last on index 7.
REQ-035 Line 2 pulses at ticks 1, 4 and 6 -> out_time for index 2 = 1.
REQ-036 Lines 1, 4 and 6 pulse together at tick 3 -> all three report 3.
REQ-037 out_ready low for 5 cycles on index 4 -> word held stable, no skip or duplicate, 8 words total.
REQ-038 start pulsed during CAPTURE and GAP -> ignored; next window begins only after IDLE; period is 19 cycles with defaults.
REQ-039 Reset asserted at tick 4, then a new start -> out_valid stays 0 through reset; next drain reflects only new-window pulses.

Source files
------------

// File: rtl/temporal_pkg.sv
// Shared types and width helpers for the temporal window sequencer.
package temporal_pkg;
   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_GAP} state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int time_width(input int w);
      return $clog2(w + 1);
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 0) ? $clog2(n + 1) : 1;
   endfunction
endpackage

// File: rtl/arrival_capture.sv
// One input line: latches the tick of its first spike; reports WINDOW when silent.
module arrival_capture
   import temporal_pkg::*;
#(
   parameter int WINDOW = 8,
   parameter int TW     = time_width(WINDOW)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          enable,
   input  logic          line,
   input  logic [TW-1:0] tick,
   output logic [TW-1:0] arrival
);
   logic          captured;
   logic [TW-1:0] stamp;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         captured <= 1'b0;
         stamp    <= '0;
      end else if (clear) begin
         captured <= 1'b0;
         stamp    <= '0;
      end else if (enable && line && !captured) begin
         captured <= 1'b1;
         stamp    <= tick;
      end
   end

   assign arrival = captured ? stamp : TW'(WINDOW);
endmodule

// File: rtl/temporal_window_sequencer.sv
// Opens a fixed capture window, time-stamps first spikes per line, then drains
// one (index, time) word per handshake followed by a decoder clearance gap.
module temporal_window_sequencer
   import temporal_pkg::*;
#(
   parameter int NUM_LINES = 8,
   parameter int WINDOW    = 8,
   parameter int GAP       = 2
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             start,
   input  logic [NUM_LINES-1:0]             incoming_lines,
   output logic                             window_start,
   output logic                             window_open,
   output logic                             busy,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [idx_width(NUM_LINES)-1:0]  out_index,
   output logic [time_width(WINDOW)-1:0]    out_time,
   output logic                             out_last
);
   localparam int IW = idx_width(NUM_LINES);
   localparam int TW = time_width(WINDOW);
   localparam int GW = cnt_width(GAP);

   state_t state, next;
   logic [TW-1:0] tick;
   logic [IW-1:0] idx;
   logic [GW-1:0] gap_cnt;
   logic          hs, last_word, drain_done, tick_end, gap_end;
   logic [NUM_LINES-1:0][TW-1:0] line_time;

   assign tick_end   = (tick == TW'(WINDOW - 1));
   assign last_word  = (idx == IW'(NUM_LINES - 1));
   assign hs         = (state == S_DRAIN) && out_ready;
   assign drain_done = hs && last_word;
   assign gap_end    = (gap_cnt == GW'((GAP > 0) ? GAP - 1 : 0));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= next;
   end

   always_comb begin
      next = state;
      case (state)
         S_IDLE:    if (start) next = S_CAPTURE;
         S_CAPTURE: if (tick_end) next = S_DRAIN;
         S_DRAIN:   if (drain_done) next = (GAP == 0) ? S_IDLE : S_GAP;
         S_GAP:     if (gap_end) next = S_IDLE;
         default:   next = S_IDLE;
      endcase
   end

   // Counters idle at zero so each phase starts from a clean count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tick    <= '0;
         idx     <= '0;
         gap_cnt <= '0;
      end else begin
         tick    <= (state == S_CAPTURE && !tick_end) ? tick + 1'b1 : '0;
         gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
         if (drain_done) idx <= '0;
         else if (hs)    idx <= idx + 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
      arrival_capture #(.WINDOW(WINDOW), .TW(TW)) u_cap (
         .clock   (clock),
         .reset   (reset),
         .clear   (drain_done),
         .enable  (state == S_CAPTURE),
         .line    (incoming_lines[g]),
         .tick    (tick),
         .arrival (line_time[g])
      );
   end

   assign window_start = (state == S_CAPTURE) && (tick == '0);
   assign window_open  = (state == S_CAPTURE);
   assign busy         = (state != S_IDLE);
   assign out_valid    = (state == S_DRAIN);
   assign out_index    = idx;
   assign out_time     = (state == S_DRAIN) ? line_time[idx] : '0;
   assign out_last     = (state == S_DRAIN) && last_word;
endmodule

// File: tb/tb_temporal_window_sequencer.sv
// Randomized bench for temporal_window_sequencer against a first-spike reference model.
module tb_temporal_window_sequencer;
   localparam int N = 8;
   localparam int W = 8;
   localparam int G = 2;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] incoming_lines = '0;
   logic         out_ready = 1'b0;
   logic         window_start, window_open, busy, out_valid, out_last;
   logic [2:0]   out_index;
   logic [3:0]   out_time;

   int checks = 0;
   int errors = 0;
   logic [N-1:0] pat [W];

   temporal_window_sequencer #(.NUM_LINES(N), .WINDOW(W), .GAP(G)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .incoming_lines (incoming_lines),
      .window_start   (window_start),
      .window_open    (window_open),
      .busy           (busy),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_index      (out_index),
      .out_time       (out_time),
      .out_last       (out_last)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_pat();
      for (int t = 0; t < W; t++) pat[t] = '0;
   endtask

   task automatic rand_pat();
      for (int t = 0; t < W; t++)
         for (int i = 0; i < N; i++) pat[t][i] = ($urandom % 6) == 0;
   endtask

   // Reference: each line reports the earliest tick it was high, or W if never.
   task automatic run_window(input int ready_pct, input bit noise, input int stall_idx, input int stall_len);
      int expt [N];
      int k, stalled, guard;
      logic r, pv, pr;
      logic [2:0] pidx;
      logic [3:0] ptime;
      for (int i = 0; i < N; i++) begin
         expt[i] = W;
         for (int t = W - 1; t >= 0; t--) if (pat[t][i]) expt[i] = t;
      end
      chk("idle_busy", busy, 0);
      start = 1'b1; incoming_lines = N'($urandom); out_ready = 1'b0;
      step();
      for (int t = 0; t < W; t++) begin
         chk("win_open", window_open, 1);
         chk("win_start", window_start, (t == 0));
         chk("cap_valid", out_valid, 0);
         incoming_lines = pat[t];
         start = noise ? 1'($urandom % 2) : 1'b0;
         step();
      end
      k = 0; stalled = 0; guard = 0; pv = 0; pr = 0; pidx = '0; ptime = '0;
      while (k < N && guard < 400) begin
         incoming_lines = N'($urandom);
         start = noise ? 1'($urandom % 2) : 1'b0;
         chk("drain_valid", out_valid, 1);
         if (pv && !pr) begin
            chk("hold_index", out_index, pidx);
            chk("hold_time", out_time, ptime);
         end
         chk("index", out_index, k);
         chk("time", out_time, expt[k]);
         chk("last", out_last, (k == N - 1));
         if (stall_idx >= 0) begin
            r = !(k == stall_idx && stalled < stall_len);
            if (!r) stalled++;
         end else r = ($urandom % 100) < ready_pct;
         out_ready = r;
         pv = out_valid; pr = r; pidx = out_index; ptime = out_time;
         if (r) k++;
         guard++;
         step();
      end
      chk("drain_words", k, N);
      out_ready = 1'b0; incoming_lines = '0;
      for (int g = 0; g < G; g++) begin
         chk("gap_busy", busy, 1);
         chk("gap_valid", out_valid, 0);
         start = noise;
         step();
      end
      start = 1'b0;
      chk("idle_after", busy, 0);
      chk("idle_valid", out_valid, 0);
   endtask

   initial begin
      int cnt, last, seen;
      #1 reset = 1'b0;
      step(); step();
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_open", window_open, 0);
      chk("rst_wstart", window_start, 0);
      chk("rst_last", out_last, 0);
      chk("rst_index", out_index, 0);
      chk("rst_time", out_time, 0);
      reset = 1'b1;
      step();

      // Sparse spikes including boundary ticks 0 and W-1.
      clear_pat(); pat[0][0] = 1; pat[5][3] = 1; pat[7][7] = 1;
      run_window(100, 0, -1, 0);
      // Repeated pulses on one line keep the first tick.
      clear_pat(); pat[1][2] = 1; pat[4][2] = 1; pat[6][2] = 1;
      run_window(100, 0, -1, 0);
      // Simultaneous arrivals.
      clear_pat(); pat[3] = 8'b0101_0010;
      run_window(100, 0, -1, 0);
      // Backpressure on index 4.
      rand_pat();
      run_window(100, 0, 4, 5);

      // Start held high: CAPTURE/GAP starts ignored, period fixed.
      start = 1'b1; out_ready = 1'b1; incoming_lines = '0;
      cnt = 0; last = -1; seen = 0;
      while (seen < 3 && cnt < 200) begin
         if (window_start) begin
            if (last >= 0) chk("period", cnt - last, 1 + W + N + G);
            last = cnt; seen++;
         end
         step(); cnt++;
      end
      chk("period_seen", seen, 3);
      start = 1'b0;
      cnt = 0;
      while (busy && cnt < 100) begin step(); cnt++; end
      chk("period_idle", busy, 0);
      out_ready = 1'b0;

      // Reset in the middle of a capture.
      step();
      start = 1'b1; step(); start = 1'b0;
      for (int t = 0; t < 4; t++) begin
         incoming_lines = (t == 1) ? 8'b0010_0001 : 8'b0;
         step();
      end
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_open", window_open, 0);
      chk("mid_rst_time", out_time, 0);
      chk("mid_rst_index", out_index, 0);
      step();
      chk("mid_rst_valid2", out_valid, 0);
      #2 reset = 1'b1;
      incoming_lines = '1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("post_rst_busy", busy, 0);
         chk("post_rst_valid", out_valid, 0);
      end
      clear_pat(); pat[2][4] = 1; pat[6][1] = 1;
      run_window(100, 0, -1, 0);

      // Random traffic with junk starts and random backpressure.
      for (int w = 0; w < 25; w++) begin
         rand_pat();
         run_window(60, 1, -1, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
